// File: rtl/btn_filter.sv
// Push-button conditioner: synchronize, debounce, emit one-cycle pulse per accepted press.
// Latency: SYNC_STAGES-1+DEBOUNCE_CYCLES edges from first high sample to sig high (5 with defaults).
// Backpressure: none; free-running single-bit path with no flow control.
module btn_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic sig
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CW-1:0]          r_cnt;
  logic                   r_sig;

  logic                   w_s;
  logic                   w_stable_next;
  logic [CW-1:0]          w_cnt_next;

  assign w_s = r_sync[SYNC_STAGES-1];
  assign sig = r_sig;

  // Shift the raw button through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  // Acceptance clears the counter, so it can never run past DEBOUNCE_CYCLES-1.
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = '0;
    if (w_s != r_stable) begin
      if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        w_stable_next = w_s;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // Register debounced level, counter, and the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_sig    <= 1'b0;
    end else begin
      r_stable <= w_stable_next;
      r_cnt    <= w_cnt_next;
      r_sig    <= w_stable_next & ~r_stable;
    end
  end

endmodule

// File: tb/tb_btn_filter.sv
// Directed bench for btn_filter with default parameters.
// Each step drives btn/rst just after a rising edge, then checks sig after the next edge.
// A press first sampled at step i is expected to show sig high at step i+5 only.
module tb_btn_filter;

  logic clk;
  logic rst;
  logic btn;
  logic sig;

  int checks;
  int errors;
  int pulses;

  btn_filter #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sig(sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent tally of every cycle sig is seen high.
  always @(negedge clk) begin
    if (sig === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: sig=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: count=%0d expected %0d", tag, obs, exp);
    end
  endtask

  // One step: drive btn, advance one edge, check sig.
  task automatic cyc(input logic b, input logic e, input string tag);
    btn = b;
    @(posedge clk);
    #1;
    chk(tag, sig, e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $sformatf("%s_idle[%0d]", tag, i));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    rst    = 1'b1;
    btn    = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, "reset0");
    cyc(1'b0, 1'b0, "reset1");
    rst = 1'b0;

    // Test 1: rise sampled at edge 2 after reset, held 10 cycles, then release
    cyc(1'b0, 1'b0, "t1_e1");
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 5), $sformatf("t1_hold[%0d]", i));
    for (int i = 0; i < 89; i++) cyc(1'b0, (i == 0) ? 1'b0 : 1'b0, $sformatf("t1_rel[%0d]", i));
    chk_int("t1_pulses", pulses, 1);

    // Test 2: 3-cycle high excursion is rejected
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, $sformatf("t2_hi[%0d]", i));
    idle(10, "t2");
    chk_int("t2_pulses", pulses, 1);

    // Test 3: bounce 1,0,1,0 then final rise held
    cyc(1'b1, 1'b0, "t3_b0");
    cyc(1'b0, 1'b0, "t3_b1");
    cyc(1'b1, 1'b0, "t3_b2");
    cyc(1'b0, 1'b0, "t3_b3");
    for (int i = 0; i < 15; i++) cyc(1'b1, (i == 5), $sformatf("t3_hold[%0d]", i));
    idle(10, "t3");
    chk_int("t3_pulses", pulses, 2);

    // Test 4: held 50 cycles gives exactly one pulse
    for (int i = 0; i < 50; i++) cyc(1'b1, (i == 5), $sformatf("t4_hold[%0d]", i));
    idle(10, "t4");
    chk_int("t4_pulses", pulses, 3);

    // Test 5: press, release 6 cycles, press again
    for (int i = 0; i < 8; i++) cyc(1'b1, (i == 5), $sformatf("t5_p1[%0d]", i));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, $sformatf("t5_rel[%0d]", i));
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 5), $sformatf("t5_p2[%0d]", i));
    idle(10, "t5");
    chk_int("t5_pulses", pulses, 5);

    // Test 6: reset mid-count with button held; count restarts from release
    cyc(1'b1, 1'b0, "t6_rise0");
    cyc(1'b1, 1'b0, "t6_rise1");
    rst = 1'b1;
    cyc(1'b1, 1'b0, "t6_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 5), $sformatf("t6_hold[%0d]", i));
    idle(10, "t6");
    chk_int("t6_pulses", pulses, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
